// File: rtl/clock_time_counter.sv
// -----------------------------------------------------------------------------
// clock_time_counter
//
// Time-of-day counter. It counts seconds, minutes and hours in packed BCD and
// uses a 24-hour range (00:00:00-23:59:59). The input is the one-second enable
// pulse from the seconds-tick generator. The output time feeds the
// seven-segment display driver.
//
// The counter supports a synchronous time-set load. A load is checked for
// legality first, and an illegal load is rejected with a one-cycle load_err
// pulse. Rollover pulses (min_tick / hour_tick / day_tick) are registered and
// last one cycle each.
//
// Optional feature macro: CLOCK_ALARM_EN
//   When defined, the design adds alarm_hh/alarm_mm/alarm_arm inputs and a
//   registered alarm output.
//
// Parameters
//   RESET_HH   BCD hour loaded on reset. It must be a legal hour (00-23).
//
// Ports
//   clk        system clock. All logic runs on the rising edge.
//   rst        asynchronous, active-high reset
//   second     one-cycle tick enable. It may be high on consecutive cycles.
//   load       one-cycle request to load load_hh/load_mm/load_ss
//   load_hh    BCD hours to load
//   load_mm    BCD minutes to load
//   load_ss    BCD seconds to load
//   hh/mm/ss   registered BCD time
//   min_tick   one-cycle pulse: seconds wrapped 59->00
//   hour_tick  one-cycle pulse: minutes wrapped 59->00
//   day_tick   one-cycle pulse: 23:59:59->00:00:00
//   load_err   one-cycle pulse: load rejected as illegal
//   alarm_hh   (CLOCK_ALARM_EN) BCD alarm hour
//   alarm_mm   (CLOCK_ALARM_EN) BCD alarm minute
//   alarm_arm  (CLOCK_ALARM_EN) alarm enable. Low clears a raised alarm.
//   alarm      (CLOCK_ALARM_EN) registered alarm flag
//
// Per-cycle priority: load, then second, otherwise hold. A load consumes a
// coincident second. That means no increment happens and no rollover pulse
// is produced.
// -----------------------------------------------------------------------------
module clock_time_counter #(
  parameter logic [7:0] RESET_HH = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       second,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  output logic       load_err
`ifdef CLOCK_ALARM_EN
  ,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_arm,
  output logic       alarm
`endif
);

  // Modulo-60 BCD increment. 59 wraps to 00.
  function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] < 4'd9)      r = {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] < 4'd5) r = {v[7:4] + 4'd1, 4'd0};
    else                    r = 8'h00;
    return r;
  endfunction

  // 24-hour BCD increment. 23->00 is explicit. 09->10 and 19->20 come from
  // the units carry.
  function automatic logic [7:0] bcd_inc_24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)         r = 8'h00;
    else if (v[3:0] < 4'd9) r = {v[7:4], v[3:0] + 4'd1};
    else                    r = {v[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  // Output registers. There is no other state in the design.
  logic [7:0] r_hh, r_mm, r_ss;
  logic       r_min_tick, r_hour_tick, r_day_tick, r_load_err;

  // Combinational next-state terms.
  logic [7:0] w_ss_inc, w_mm_inc, w_hh_inc;
  logic       w_ss_wrap, w_mm_wrap, w_hh_wrap;
  logic       w_nib_ok, w_load_ok;

  assign w_ss_inc  = bcd_inc_60(r_ss);
  assign w_mm_inc  = bcd_inc_60(r_mm);
  assign w_hh_inc  = bcd_inc_24(r_hh);

  // Each wrap condition includes the wrap of the field below it, so
  // w_hh_wrap is true only at 23:59:59.
  assign w_ss_wrap = (r_ss == 8'h59);
  assign w_mm_wrap = w_ss_wrap && (r_mm == 8'h59);
  assign w_hh_wrap = w_mm_wrap && (r_hh == 8'h23);

  // The range compares are valid only because every nibble is checked to be
  // a decimal digit first. After that check, packed-BCD order matches
  // numeric order.
  assign w_nib_ok  = (load_hh[7:4] <= 4'd9) && (load_hh[3:0] <= 4'd9) &&
                     (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                     (load_ss[7:4] <= 4'd9) && (load_ss[3:0] <= 4'd9);
  assign w_load_ok = w_nib_ok && (load_hh <= 8'h23) &&
                     (load_mm <= 8'h59) && (load_ss <= 8'h59);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hh        <= RESET_HH;
      r_mm        <= 8'h00;
      r_ss        <= 8'h00;
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day_tick  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      // The pulses default low, so each one lasts exactly one cycle.
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day_tick  <= 1'b0;
      r_load_err  <= 1'b0;
      if (load) begin
        if (w_load_ok) begin
          r_hh <= load_hh;
          r_mm <= load_mm;
          r_ss <= load_ss;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (second) begin
        r_ss <= w_ss_inc;
        if (w_ss_wrap) begin
          r_min_tick <= 1'b1;
          r_mm       <= w_mm_inc;
        end
        if (w_mm_wrap) begin
          r_hour_tick <= 1'b1;
          r_hh        <= w_hh_inc;
        end
        if (w_hh_wrap) begin
          r_day_tick <= 1'b1;
        end
      end
    end
  end

  assign hh        = r_hh;
  assign mm        = r_mm;
  assign ss        = r_ss;
  assign min_tick  = r_min_tick;
  assign hour_tick = r_hour_tick;
  assign day_tick  = r_day_tick;
  assign load_err  = r_load_err;

`ifdef CLOCK_ALARM_EN
  logic       r_alarm;
  logic [7:0] w_next_mm, w_next_hh;
  logic       w_alarm_hit;

  // A tick lands on hh:mm:00 only when the seconds field wraps. In that
  // case, the next minute and hour come from the same carry chain as the
  // main counter.
  assign w_next_mm   = w_mm_inc;
  assign w_next_hh   = w_mm_wrap ? w_hh_inc : r_hh;
  assign w_alarm_hit = second && !load && w_ss_wrap &&
                       (w_next_mm == alarm_mm) && (w_next_hh == alarm_hh);

  // When alarm_arm is low, the clear wins over a coincident hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_alarm <= 1'b0;
    else if (!alarm_arm)  r_alarm <= 1'b0;
    else if (w_alarm_hit) r_alarm <= 1'b1;
  end

  assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// -----------------------------------------------------------------------------
// Testbench for clock_time_counter (default build, RESET_HH = 8'h00).
//
// Directed vectors with hand-computed expectations. Each step applies one
// cycle of inputs at the falling edge. It then samples the outputs at the
// next falling edge, half a cycle after the active edge. The sampled value
// is compared against the expected vector {hh, mm, ss, min, hour, day, err}.
// -----------------------------------------------------------------------------
module tb_clock_time_counter;

  localparam int W = 28;

  logic       clk;
  logic       rst;
  logic       second;
  logic       load;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh, mm, ss;
  logic       min_tick, hour_tick, day_tick, load_err;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_q[$];

  clock_time_counter #(.RESET_HH(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .second    (second),
    .load      (load),
    .load_hh   (load_hh),
    .load_mm   (load_mm),
    .load_ss   (load_ss),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .min_tick  (min_tick),
    .hour_tick (hour_tick),
    .day_tick  (day_tick),
    .load_err  (load_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  // Pulse nibble order: {min_tick, hour_tick, day_tick, load_err}.
  function automatic logic [W-1:0] mk(input logic [7:0] h, input logic [7:0] m,
                                      input logic [7:0] s, input logic [3:0] p);
    return {h, m, s, p};
  endfunction

  function automatic logic [W-1:0] observed();
    return {hh, mm, ss, min_tick, hour_tick, day_tick, load_err};
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got hh:mm:ss=%h:%h:%h pulses(m,h,d,e)=%b, expected %h:%h:%h pulses=%b",
               tag, got[27:20], got[19:12], got[11:4], got[3:0],
               exp[27:20], exp[19:12], exp[11:4], exp[3:0]);
    end
  endtask

  // ---------------- driver ----------------
  // The caller must be at a falling edge. The task drives the inputs for
  // one cycle, waits until the next falling edge, and then compares the
  // outputs against the expected vector queued for this step.
  task automatic step(input string tag, input logic ld, input logic [7:0] th,
                      input logic [7:0] tm, input logic [7:0] ts,
                      input logic sec, input logic [W-1:0] exp);
    load    = ld;
    load_hh = th;
    load_mm = tm;
    load_ss = ts;
    second  = sec;
    exp_q.push_back(exp);
    @(negedge clk);
    check_eq(tag, observed(), exp_q.pop_front());
  endtask

  task automatic idle(input string tag, input logic [W-1:0] exp);
    step(tag, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, exp);
  endtask

  task automatic tick(input string tag, input logic [W-1:0] exp);
    step(tag, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, exp);
  endtask

  task automatic ld(input string tag, input logic [7:0] th, input logic [7:0] tm,
                    input logic [7:0] ts, input logic [W-1:0] exp);
    step(tag, 1'b1, th, tm, ts, 1'b0, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    second   = 1'b0;
    load     = 1'b0;
    load_hh  = 8'h00;
    load_mm  = 8'h00;
    load_ss  = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("reset_state", observed(), mk(8'h00, 8'h00, 8'h00, 4'b0000));
    rst = 1'b0;

    // Count to 12:34:56.
    ld  ("load_123455", 8'h12, 8'h34, 8'h55, mk(8'h12, 8'h34, 8'h55, 4'b0000));
    tick("tick_123456",                      mk(8'h12, 8'h34, 8'h56, 4'b0000));

    // Async reset mid-cycle, with a second pending. The outputs must clear
    // before any clock edge.
    second = 1'b1;
    #2 rst = 1'b1;
    #1 check_eq("async_reset", observed(), mk(8'h00, 8'h00, 8'h00, 4'b0000));
    @(negedge clk);
    check_eq("reset_held_sec", observed(), mk(8'h00, 8'h00, 8'h00, 4'b0000));
    rst = 1'b0;
    idle("post_reset_idle", mk(8'h00, 8'h00, 8'h00, 4'b0000));

    // Seconds -> minute wrap.
    ld  ("load_000058", 8'h00, 8'h00, 8'h58, mk(8'h00, 8'h00, 8'h58, 4'b0000));
    tick("tick_000059",                      mk(8'h00, 8'h00, 8'h59, 4'b0000));
    tick("tick_000100",                      mk(8'h00, 8'h01, 8'h00, 4'b1000));
    idle("min_tick_clear",                   mk(8'h00, 8'h01, 8'h00, 4'b0000));

    // Day wrap: all three pulses assert together.
    ld  ("load_235959", 8'h23, 8'h59, 8'h59, mk(8'h23, 8'h59, 8'h59, 4'b0000));
    tick("day_wrap",                         mk(8'h00, 8'h00, 8'h00, 4'b1110));
    idle("day_pulses_clear",                 mk(8'h00, 8'h00, 8'h00, 4'b0000));

    // Hour digit carries.
    ld  ("load_095959", 8'h09, 8'h59, 8'h59, mk(8'h09, 8'h59, 8'h59, 4'b0000));
    tick("carry_0910",                       mk(8'h10, 8'h00, 8'h00, 4'b1100));
    ld  ("load_195959", 8'h19, 8'h59, 8'h59, mk(8'h19, 8'h59, 8'h59, 4'b0000));
    tick("carry_1920",                       mk(8'h20, 8'h00, 8'h00, 4'b1100));

    // Illegal loads leave the time unchanged.
    ld  ("illegal_hh24",  8'h24, 8'h00, 8'h00, mk(8'h20, 8'h00, 8'h00, 4'b0001));
    idle("load_err_clear",                     mk(8'h20, 8'h00, 8'h00, 4'b0000));
    ld  ("illegal_mm5A",  8'h12, 8'h5A, 8'h00, mk(8'h20, 8'h00, 8'h00, 4'b0001));
    ld  ("illegal_hh1A",  8'h1A, 8'h00, 8'h00, mk(8'h20, 8'h00, 8'h00, 4'b0001));
    ld  ("illegal_ss60",  8'h12, 8'h00, 8'h60, mk(8'h20, 8'h00, 8'h00, 4'b0001));

    // A load coincident with second consumes the tick.
    step("load_with_sec", 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, mk(8'h12, 8'h00, 8'h00, 4'b0000));
    step("load_sec_2359", 1'b1, 8'h23, 8'h59, 8'h59, 1'b1, mk(8'h23, 8'h59, 8'h59, 4'b0000));
    idle("no_wrap_pulses",                                 mk(8'h23, 8'h59, 8'h59, 4'b0000));

    // Back-to-back second pulses, with no dropped ticks.
    ld  ("load_005958", 8'h00, 8'h59, 8'h58, mk(8'h00, 8'h59, 8'h58, 4'b0000));
    tick("b2b_1",                            mk(8'h00, 8'h59, 8'h59, 4'b0000));
    tick("b2b_2",                            mk(8'h01, 8'h00, 8'h00, 4'b1100));
    tick("b2b_3",                            mk(8'h01, 8'h00, 8'h01, 4'b0000));
    tick("b2b_4",                            mk(8'h01, 8'h00, 8'h02, 4'b0000));
    idle("b2b_hold",                         mk(8'h01, 8'h00, 8'h02, 4'b0000));

    // Tens-digit carry within seconds.
    ld  ("load_000009", 8'h00, 8'h00, 8'h09, mk(8'h00, 8'h00, 8'h09, 4'b0000));
    tick("ss_tens_carry",                    mk(8'h00, 8'h00, 8'h10, 4'b0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_time_counter.md
# clock_time_counter

Consumer of the one-second enable pulse from the clock's seconds-tick generator. Counts seconds, minutes and hours in packed BCD (24-hour, 00:00:00-23:59:59) and supports a synchronous time-set load. Emits registered rollover pulses for downstream display and alarm logic. Sits between the tick generator and the seven-segment display driver.

## Interface
- RESET_HH, default 8'h00: BCD hour value applied on reset; must be a legal hour (00-23).
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- second  in  1  one-cycle enable pulse, nominally once per second; may be asserted on consecutive cycles
- load  in  1  one-cycle request to load load_hh/load_mm/load_ss
- load_hh  in  8  BCD hours to load, tens in [7:4], units in [3:0]
- load_mm  in  8  BCD minutes to load
- load_ss  in  8  BCD seconds to load
- hh  out  8  BCD hours, registered
- mm  out  8  BCD minutes, registered
- ss  out  8  BCD seconds, registered
- min_tick  out  1  one-cycle pulse: seconds wrapped 59->00
- hour_tick  out  1  one-cycle pulse: minutes wrapped 59->00
- day_tick  out  1  one-cycle pulse: time wrapped 23:59:59->00:00:00
- load_err  out  1  one-cycle pulse: load rejected as illegal

## Operation
- Reset values: hh=RESET_HH, mm=8'h00, ss=8'h00. min_tick, hour_tick, day_tick and load_err are all 0.
- Per-cycle priority: load first, then second, otherwise hold.
- Load legality:
  - Every nibble must be <= 9.
  - load_hh must be <= 8'h23; load_mm and load_ss must be <= 8'h59.
  - A legal load replaces all three fields at once.
  - An illegal load changes nothing and pulses load_err.
- A load cycle that coincides with second consumes that tick. The loaded value is not incremented, and no rollover pulses are generated.
- Tick increment, units digit: if units < 9, increment units; otherwise units=0 and carry into tens.
- Seconds and minutes tens: if tens < 5, increment tens; otherwise the field wraps to 00 and carries into the next field.
- Hours: 09->10 and 19->20 through the units carry; 23->00 is explicit.
- Rollover pulses:
  - min_tick asserts on every ss wrap.
  - hour_tick asserts when ss and mm wrap together.
  - day_tick asserts when all three fields wrap.
  - Pulses from one wrap event assert together (e.g. 23:59:59 raises all three).
- No internal state exists beyond the output registers; everything else is combinational next-state logic.

## Timing
- Latency:
  - second at edge N: the updated time and any rollover pulses are visible after edge N+1, held for exactly one cycle in the case of the pulses.
  - load at edge N: the new time, or load_err, is visible after edge N+1.
- Back-to-back second pulses advance the time by one second per cycle, with no dropped ticks.
- When rst asserts, outputs take their reset values immediately, without waiting for a clock edge. A second or load present during reset is discarded. The first edge after rst deasserts processes inputs normally.

## Configuration
- CLOCK_ALARM_EN defined adds these ports:
  - alarm_hh (in, 8, BCD)
  - alarm_mm (in, 8, BCD)
  - alarm_arm (in, 1)
  - alarm (out, 1, registered, reset 0)
- Alarm set: alarm sets on the cycle a tick (not a load) makes hh:mm:ss equal to alarm_hh:alarm_mm:00 while alarm_arm=1.
- Alarm clear: alarm stays set until alarm_arm=0 is sampled, which clears it on the next edge. Clearing has priority over setting.
- CLOCK_ALARM_EN undefined: none of these ports or registers exist.

## Test plan
- Reset: assert rst mid-count at 12:34:56 -> hh/mm/ss read 00:00:00 (RESET_HH=00) before the next edge; all pulses are 0.
- Seconds/minute wrap: load 00:00:58, then two second pulses -> 00:00:59, then 00:01:00 with min_tick=1 for one cycle; hour_tick=0.
- Day wrap: load 23:59:59, then one second pulse -> 00:00:00 with min_tick, hour_tick and day_tick all 1 for one cycle.
- Hour digit carry: load 09:59:59, tick -> 10:00:00; load 19:59:59, tick -> 20:00:00.
- Load checks:
  - load 8'h24:00:00 -> load_err=1, time unchanged.
  - load 12:5A:00 -> load_err=1.
  - load 12:00:00 coincident with second -> time reads 12:00:00, not 12:00:01.
- Alarm (with CLOCK_ALARM_EN): alarm_arm=1, alarm 07:30, load 07:29:59, tick -> alarm=1 at 07:30:00. Then drop alarm_arm -> alarm=0 on the next edge. Loading 07:30:00 directly does not set the alarm.
